bus_memory_model: RTL and testbench
===================================

# bus_memory_model

Parametrised word-addressed memory and halt monitor on the processor's memory bus (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`). It replaces the bare bus hookup in the top-level bench. It adds configurable read and write wait states with a `mem_ready` handshake, range checking, and a protocol-error flag. A memory-mapped halt register captures a completion code and freezes a cycle counter, so simulations self-terminate with a result.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH ``: data and address width.
- `DEPTH_LOG2`, default 10: memory holds 2^DEPTH_LOG2 words.
- `READ_LAT`, default 2: read wait cycles, range 1..15.
- `WRITE_LAT`, default 1: write wait cycles, range 1..15.
- `HALT_ADDR`, default all-ones minus 15 (0xFFFF_FFF0 at 32 bits): halt register address.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `mem_read`, input, 1: read request.
- `mem_write`, input, 1: write request.
- `mem_addr`, input, WORD_WIDTH: byte address. Bits [1:0] are ignored.
- `mem_wdata`, input, WORD_WIDTH: write data.
- `mem_rdata`, output, WORD_WIDTH: read data. Valid when `mem_ready` is high, and held until the next read completes.
- `mem_ready`, output, 1: one-cycle completion pulse.
- `halt`, output, 1: sticky; set by a write to `HALT_ADDR`.
- `halt_code`, output, WORD_WIDTH: data of the first halt write.
- `err`, output, 1: sticky protocol/range error.
- `cycle_count`, output, 32: cycles since reset release. Frozen once `halt` is set.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `mem_read` or `mem_write` is high at a rising edge, latch op, address and wdata. Load `lat_cnt` with LAT-1 (LAT = READ_LAT or WRITE_LAT) and go to BUSY.
- **BUSY**
  - While `lat_cnt` ≠ 0, decrement it.
  - When `lat_cnt` = 0, perform the access, assert `mem_ready` and go to DONE.
  - Latched fields are used for the access. Bus inputs are ignored while BUSY.
- **DONE**
  - `mem_ready` is high for exactly this one cycle. Next edge goes to IDLE unconditionally; no request is sampled at that edge.
- Word index is `mem_addr[DEPTH_LOG2+1:2]`.
- **Out of range** (any address bit above DEPTH_LOG2+1 set, and address ≠ HALT_ADDR):
  - Read returns 0; write is dropped.
  - `err` is set; the handshake still completes.
- **Both `mem_read` and `mem_write` high when sampled**: treated as a write, and `err` is set.
- **Write to HALT_ADDR**:
  - If `halt` = 0: set `halt`, latch `halt_code` = wdata. Memory is not written.
  - Later halt writes change nothing.
- **Read of HALT_ADDR**: returns `halt_code`.
- Requests after `halt` are still serviced normally.
- `cycle_count` increments every cycle after reset release while `halt` = 0. It wraps modulo 2^32.

## Timing
- **Reset** (asynchronous assert, synchronous deassert by design above): FSM = IDLE, `lat_cnt` = 0, `mem_ready` = 0, `mem_rdata` = 0, `halt` = 0, `halt_code` = 0, `err` = 0, `cycle_count` = 0.
  - Memory array contents are unaffected by reset.
- **Reset mid-transaction**: the access is abandoned, with no write and no `mem_ready`.
- **Latency**: a request sampled at edge E0 gives `mem_ready` high from edge E0+LAT to edge E0+LAT+1.
  - The write commits at edge E0+LAT.
  - `mem_rdata` updates at edge E0+LAT.
- **Throughput**: one access per LAT+2 cycles. The earliest next sample is edge E0+LAT+2.
  - The requester must deassert or replace its request at edge E0+LAT+1.
  - A request still held at edge E0+LAT+2 is a new access.
- **Request withdrawn while BUSY**: the transaction still completes with the latched fields.
- **Halt and cycle counter**:
  - `halt` and `halt_code` update at the commit edge.
  - The count value at that edge is the final `cycle_count`; it does not increment after that edge.

## Test plan
- **Read latency**: READ_LAT=2; write 0xDEADBEEF to 0x10, then read 0x10.
  - `mem_ready` comes 2 edges after each sample.
  - `mem_rdata` = 0xDEADBEEF while ready, and holds after ready drops.
- **Back-to-back writes**: WRITE_LAT=3; write to 0x0, 0x4 and 0x8 with the request held continuously.
  - Exactly 3 `mem_ready` pulses, 5 cycles apart.
  - Read-back of each address returns its data.
- **Range and conflict errors**: DEPTH_LOG2=10; write to 0x1000, then read 0x1000.
  - Read returns 0 and `err` = 1.
  - After reset, `mem_read` and `mem_write` together at 0x20: treated as a write, `err` = 1.
- **Halt**: write 0x1 to HALT_ADDR at cycle 40.
  - `halt` = 1 and `halt_code` = 1; `cycle_count` freezes.
  - A second halt write of 0x2 leaves the code at 1.
  - A read of HALT_ADDR returns 1.
- **Reset mid-write**: assert `rst_n` low while BUSY on a write of 0x55 to 0x30.
  - All outputs return to reset values with no `mem_ready`.
  - Address 0x30 keeps its prior contents.

Source files
------------

// File: rtl/bus_memory_model.sv
// Word-addressed bus memory with configurable wait states, range checking and a
// memory-mapped halt register that freezes the cycle counter.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module bus_memory_model #(
  parameter int                    WORD_WIDTH = `WORD_WIDTH,
  parameter int                    DEPTH_LOG2 = 10,
  parameter int                    READ_LAT   = 2,
  parameter int                    WRITE_LAT  = 1,
  parameter logic [WORD_WIDTH-1:0] HALT_ADDR  = ~(WORD_WIDTH'(15))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  halt,
  output logic [WORD_WIDTH-1:0] halt_code,
  output logic                  err,
  output logic [31:0]           cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

  // Addresses are compared on word granularity; the byte offset never matters.
  function automatic logic is_halt_addr(input logic [WORD_WIDTH-1:2] a);
    return a == HALT_ADDR[WORD_WIDTH-1:2];
  endfunction

  function automatic logic out_of_range(input logic [WORD_WIDTH-1:2] a);
    return (|a[WORD_WIDTH-1:DEPTH_LOG2+2]) && !is_halt_addr(a);
  endfunction

  logic [WORD_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

  state_t                state_r;
  logic [3:0]            lat_cnt_r;
  logic                  op_write_r;
  logic                  conflict_r;
  logic [WORD_WIDTH-1:2] addr_r;
  logic [WORD_WIDTH-1:0] wdata_r;

  logic                  commit_s;
  logic                  halt_hit_s;
  logic                  oor_s;
  logic                  mem_we_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  unused_s;

  assign commit_s   = (state_r == BUSY) && (lat_cnt_r == 4'd0);
  assign halt_hit_s = is_halt_addr(addr_r);
  assign oor_s      = out_of_range(addr_r);
  assign idx_s      = addr_r[DEPTH_LOG2+1:2];
  assign mem_we_s   = commit_s && op_write_r && !oor_s && !halt_hit_s;
  assign unused_s   = ^mem_addr[1:0];

  // Memory array: no reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= wdata_r;
    end
  end

  // Request FSM, halt register, error flag and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lat_cnt_r   <= 4'd0;
      op_write_r  <= 1'b0;
      conflict_r  <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      halt        <= 1'b0;
      halt_code   <= '0;
      err         <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      if (!halt) begin
        cycle_count <= cycle_count + 32'd1;
      end
      case (state_r)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_read || mem_write) begin
            // A simultaneous read+write is serviced as a write and flagged.
            op_write_r <= mem_write;
            conflict_r <= mem_read && mem_write;
            addr_r     <= mem_addr[WORD_WIDTH-1:2];
            wdata_r    <= mem_wdata;
            lat_cnt_r  <= mem_write ? WR_LOAD : RD_LOAD;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt_r != 4'd0) begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end else begin
            mem_ready <= 1'b1;
            state_r   <= DONE;
            if (conflict_r || oor_s) begin
              err <= 1'b1;
            end
            if (op_write_r) begin
              if (halt_hit_s && !halt) begin
                halt      <= 1'b1;
                halt_code <= wdata_r;
              end
            end else if (halt_hit_s) begin
              mem_rdata <= halt_code;
            end else if (oor_s) begin
              mem_rdata <= '0;
            end else begin
              mem_rdata <= mem[idx_s];
            end
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_memory_model.sv
// Randomized scoreboard bench: the driver predicts each access from a word-level
// memory model and a separate monitor checks every ready pulse and idle cycle.
module tb_bus_memory_model;

  localparam int          RL   = 2;
  localparam int          WL   = 3;
  localparam logic [31:0] HALT = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;
  logic [31:0] cycle_count;

  bus_memory_model #(
    .WORD_WIDTH(32), .DEPTH_LOG2(10), .READ_LAT(RL), .WRITE_LAT(WL), .HALT_ADDR(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halt(halt), .halt_code(halt_code), .err(err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          ready_edge;
    logic        err;
    logic        halt;
    logic [31:0] code;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_no = 0;
  logic [31:0] model_mem [0:1023];
  logic        m_err = 1'b0;
  logic        m_halt = 1'b0;
  logic [31:0] m_code = 32'd0;
  logic        exp_halted = 1'b0;
  logic [31:0] exp_cc = 32'd0;
  logic [31:0] exp_hold = 32'd0;

  // Edge numbering and the expected free-running cycle count.
  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (!rst_n) exp_cc <= 32'd0;
    else if (!exp_halted) exp_cc <= exp_cc + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: pops one expectation per ready pulse; checks hold and counter every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_halted = 1'b0;
        exp_hold   = 32'd0;
      end
      chk("cycle_count", cycle_count, rst_n ? exp_cc : 32'd0);
      if (mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready got=1 want=0 t=%0t", $time);
        end else begin
          e = sb.pop_front();
          chk("ready_edge", edge_no, e.ready_edge);
          if (e.is_read) begin
            chk("rdata", mem_rdata, e.rdata);
            exp_hold = e.rdata;
          end
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("halt", {31'd0, halt}, {31'd0, e.halt});
          chk("halt_code", halt_code, e.code);
          if (e.halt) exp_halted = 1'b1;
        end
      end else begin
        chk("rdata_hold", mem_rdata, exp_hold);
        if (sb.size() > 0 && edge_no > sb[0].ready_edge) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout got=none want_edge=%0d", sb[0].ready_edge);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Issue one access at a negedge and return at the negedge after edge E0+LAT+1.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit garbage);
    exp_t e;
    int   lat;
    logic ish, oor;
    ish = (a[31:2] == HALT[31:2]);
    oor = (a[31:12] != 20'd0) && !ish;
    if ((rd && wr) || oor) m_err = 1'b1;
    lat = wr ? WL : RL;
    e.is_read = !wr;
    e.rdata   = 32'd0;
    if (wr) begin
      if (ish) begin
        if (!m_halt) begin
          m_halt = 1'b1;
          m_code = d;
        end
      end else if (!oor) begin
        model_mem[a[11:2]] = d;
      end
    end else begin
      e.rdata = ish ? m_code : (oor ? 32'd0 : model_mem[a[11:2]]);
    end
    e.err        = m_err;
    e.halt       = m_halt;
    e.code       = m_code;
    e.ready_edge = edge_no + 1 + lat;
    sb.push_back(e);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    for (int i = 0; i < lat + 2; i++) begin
      @(negedge clk);
      if (garbage && i <= lat) begin
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    sb.delete();
    m_err  = 1'b0;
    m_halt = 1'b0;
    m_code = 32'd0;
    #1;
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_code", halt_code, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          rel;
    logic [31:0] a;
    logic        rd, wr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = edge_no;

    // Request held continuously across three writes.
    access(1'b0, 1'b1, 32'h0, 32'h1111_0000, 1'b0);
    access(1'b0, 1'b1, 32'h4, 32'h2222_0004, 1'b0);
    access(1'b0, 1'b1, 32'h8, 32'h3333_0008, 1'b0);
    idle(1);
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    idle(3);
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    idle(1);

    while (edge_no < rel + 39) @(negedge clk);
    access(1'b0, 1'b1, HALT, 32'h1, 1'b0);
    idle(2);
    access(1'b0, 1'b1, HALT, 32'h2, 1'b0);
    access(1'b1, 1'b0, HALT, 32'h0, 1'b0);
    idle(10);

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        7:       a = 32'h0000_1000 | ($urandom & 32'h00FF_FFFC);
        8:       a = HALT | 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      endcase
      wr = 1'($urandom);
      rd = !wr || ($urandom_range(0, 9) == 0);
      access(rd, wr, a, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(2);

    access(1'b0, 1'b1, 32'h1000, 32'hCAFE_F00D, 1'b0);
    access(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    idle(2);

    do_reset();
    access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    idle(2);

    // Abandon a write to 0x30 while it is still waiting.
    mem_write = 1'b1;
    mem_addr  = 32'h30;
    mem_wdata = 32'h55;
    @(negedge clk);
    do_reset();
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_at_end got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
